// File: rtl/conf_loader.sv
// conf_loader: receives framed configuration bytes from a UART receiver.
// Frame format: SYNC_BYTE, PAR_NUM payload bytes, 8-bit additive checksum.
// A frame is committed to conf only when the checksum matches; a bad
// checksum or an over-long gap between bytes rejects the frame.
//
// Handshake: data_valid is a one-cycle strobe with no back-pressure; data_in
// is sampled on every rising clk edge where data_valid is high. There is no
// ready signal because the block accepts a byte in every state.
module conf_loader #(
    parameter int         PAR_NUM     = 5,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         GAP_CNT_MAX = 2080
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           data_in,
    input  logic                 data_valid,
    output logic [8*PAR_NUM-1:0] conf,
    output logic                 conf_valid,
    output logic                 frame_ok,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic [7:0]           err_cnt,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;
    localparam logic [1:0] ST_COMMIT  = 2'd3;

    localparam int               GAP_W    = $clog2(GAP_CNT_MAX + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CNT_MAX - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [3:0]       LAST_IDX = 4'(PAR_NUM - 1);

    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    logic [1:0]           state_q,      state_d;
    logic [3:0]           idx_q,        idx_d;
    logic [7:0]           sum_q,        sum_d;
    logic [GAP_W-1:0]     gap_q,        gap_d;
    logic [8*PAR_NUM-1:0] shadow_q,     shadow_d;
    logic [8*PAR_NUM-1:0] conf_q,       conf_d;
    logic                 conf_valid_q, conf_valid_d;
    logic                 frame_ok_q,   frame_ok_d;
    logic                 frame_err_q,  frame_err_d;
    logic [1:0]           err_code_q,   err_code_d;
    logic [7:0]           err_cnt_q,    err_cnt_d;

    // Next-state logic: frame parsing, gap timing and error bookkeeping.
    // conf is loaded on the edge that enters COMMIT, so it and frame_ok are
    // visible during the single COMMIT cycle, one clock after the checksum.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        gap_d        = gap_q;
        shadow_d     = shadow_q;
        conf_d       = conf_q;
        conf_valid_d = conf_valid_q;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        err_cnt_d    = err_cnt_q;

        case (state_q)
            ST_PAYLOAD, ST_CHECK: begin
                if (data_valid) begin
                    // A strobe always wins over a timeout in the same cycle.
                    gap_d = '0;
                    if (state_q == ST_PAYLOAD) begin
                        for (int k = 0; k < PAR_NUM; k++) begin
                            if (idx_q == k[3:0]) begin
                                shadow_d[8*k +: 8] = data_in;
                            end
                        end
                        sum_d = sum_q + data_in;
                        idx_d = idx_q + 4'd1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_CHECK;
                        end
                    end else if (data_in == sum_q) begin
                        state_d      = ST_COMMIT;
                        conf_d       = shadow_q;
                        conf_valid_d = 1'b1;
                        frame_ok_d   = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHECKSUM;
                        err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                    end
                end else if (gap_q == GAP_LAST) begin
                    // Gap would reach GAP_CNT_MAX on this edge: abandon frame.
                    state_d     = ST_IDLE;
                    gap_d       = '0;
                    idx_d       = '0;
                    sum_d       = '0;
                    shadow_d    = '0;
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end
            default: begin
                // IDLE and COMMIT share the same hunt rules for the next byte.
                state_d = ST_IDLE;
                if (data_valid && (data_in == SYNC_BYTE)) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = '0;
                    gap_d   = '0;
                    sum_d   = '0;
                end
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            sum_q        <= '0;
            gap_q        <= '0;
            shadow_q     <= '0;
            conf_q       <= '0;
            conf_valid_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            gap_q        <= gap_d;
            shadow_q     <= shadow_d;
            conf_q       <= conf_d;
            conf_valid_q <= conf_valid_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign conf       = conf_q;
    assign conf_valid = conf_valid_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = (state_q != ST_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_conf_loader.sv
// Bench for conf_loader: directed scenarios plus a randomized byte stream
// compared against a frame-level reference model (queue of payload bytes).
module tb_conf_loader;

    localparam int         P    = 5;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         G    = 16;
    localparam int         VW   = 8*P + 14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [7:0]       data_in = 8'h00;
    logic             data_valid = 1'b0;
    logic [8*P-1:0]   conf;
    logic             conf_valid;
    logic             frame_ok;
    logic             frame_err;
    logic [1:0]       err_code;
    logic [7:0]       err_cnt;
    logic             busy;
    logic [1:0]       dbg_state;

    int total = 0;
    int bad   = 0;

    // Clock and DUT
    always #5 clk = ~clk;

    conf_loader #(.PAR_NUM(P), .SYNC_BYTE(SYNC), .GAP_CNT_MAX(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .conf       (conf),
        .conf_valid (conf_valid),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .err_cnt    (err_cnt),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Reference model: frame-level view of the byte stream
    int             m_mode;     // 0 hunting, 1 collecting payload, 2 awaiting checksum
    logic [7:0]     m_q[$];
    int             m_idle;
    logic [8*P-1:0] m_conf;
    logic           m_conf_valid, m_ok, m_err, m_busy;
    logic [1:0]     m_code;
    logic [7:0]     m_cnt;

    function automatic void model_reset();
        m_mode = 0; m_q.delete(); m_idle = 0;
        m_conf = '0; m_conf_valid = 0; m_ok = 0; m_err = 0; m_busy = 0;
        m_code = 2'b00; m_cnt = 8'd0;
    endfunction

    function automatic void model_reject(input logic [1:0] code);
        m_err = 1; m_code = code; m_mode = 0;
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] b);
        logic [7:0] s;
        m_ok = 0; m_err = 0;
        if (m_mode == 0) begin
            if (v && b == SYNC) begin
                m_mode = 1; m_q.delete(); m_idle = 0;
            end
        end else if (v) begin
            m_idle = 0;
            if (m_mode == 1) begin
                m_q.push_back(b);
                if (m_q.size() == P) m_mode = 2;
            end else begin
                s = 8'd0;
                foreach (m_q[i]) s = s + m_q[i];
                if (b == s) begin
                    for (int k = 0; k < P; k++) m_conf[8*k +: 8] = m_q[k];
                    m_conf_valid = 1; m_ok = 1; m_mode = 0;
                end else begin
                    model_reject(2'b01);
                end
            end
        end else begin
            m_idle++;
            if (m_idle == G) model_reject(2'b10);
        end
        m_busy = (m_mode != 0) || m_ok;
    endfunction

    // Driver: one clock cycle, strobe optional; outputs sampled 1 ns after the edge
    task automatic tick(input logic v, input logic [7:0] b);
        @(negedge clk);
        data_valid = v;
        data_in    = b;
        @(posedge clk);
        #1;
        model_step(v, b);
    endtask

    task automatic send7(input logic [7:0] f [7]);
        for (int i = 0; i < 7; i++) tick(1'b1, f[i]);
    endtask

    task automatic async_reset_assert();
        #2;
        rst_n      = 1'b0;
        data_valid = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [VW-1:0] out_vec();
        return {conf, conf_valid, frame_ok, frame_err, err_code, err_cnt, busy};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_conf, m_conf_valid, m_ok, m_err, m_code, m_cnt, m_busy};
    endfunction

    // Tests
    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (out_vec() !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", out_vec());
        end
        repeat (2) @(posedge clk);
        // Strobe already present when reset releases: taken on the first edge.
        @(negedge clk);
        rst_n = 1'b1; data_valid = 1'b1; data_in = SYNC;
        @(posedge clk);
        #1;
        model_step(1'b1, SYNC);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL first_strobe_busy: got %b want 1", busy);
        end
        async_reset_assert();
        total++;
        if (out_vec() !== '0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL reset_midframe: got %h want 0", out_vec());
        end
        reset_release();
    endtask

    task automatic test_good_frame();
        send7('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F});
        total++;
        if (frame_ok !== 1'b1 || conf !== 40'h0504030201 || conf_valid !== 1'b1 || err_cnt !== 8'd0) begin
            bad++; $display("FAIL good_commit: got ok=%b conf=%h cv=%b cnt=%0d want 1 0504030201 1 0",
                            frame_ok, conf, conf_valid, err_cnt);
        end
        tick(1'b0, 8'h00);
        total++;
        if (frame_ok !== 1'b0 || busy !== 1'b0 || conf !== 40'h0504030201) begin
            bad++; $display("FAIL good_after: got ok=%b busy=%b conf=%h want 0 0 0504030201", frame_ok, busy, conf);
        end
    endtask

    task automatic test_bad_checksum();
        send7('{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00});
        total++;
        if (frame_err !== 1'b1 || frame_ok !== 1'b0 || err_code !== 2'b01 || err_cnt !== 8'd1
            || conf !== 40'h0504030201 || busy !== 1'b0) begin
            bad++; $display("FAIL bad_checksum: got err=%b ok=%b code=%b cnt=%0d conf=%h busy=%b",
                            frame_err, frame_ok, err_code, err_cnt, conf, busy);
        end
        tick(1'b0, 8'h00);
        total++;
        if (frame_err !== 1'b0 || err_code !== 2'b01) begin
            bad++; $display("FAIL err_pulse_width: got err=%b code=%b want 0 01", frame_err, err_code);
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        tick(1'b1, 8'hA5); tick(1'b1, 8'h01); tick(1'b1, 8'h02);
        for (int i = 1; i < G; i++) begin
            tick(1'b0, 8'h00);
            if (frame_err !== 1'b0 || busy !== 1'b1) early++;
        end
        total++;
        if (early != 0) begin
            bad++; $display("FAIL timeout_early: got %0d early cycles want 0", early);
        end
        tick(1'b0, 8'h00);
        total++;
        if (frame_err !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0 || err_cnt !== 8'd2) begin
            bad++; $display("FAIL timeout: got err=%b code=%b busy=%b cnt=%0d want 1 10 0 2",
                            frame_err, err_code, busy, err_cnt);
        end
        send7('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F});
        total++;
        if (frame_ok !== 1'b1 || conf !== 40'h0504030201 || err_code !== 2'b10) begin
            bad++; $display("FAIL timeout_recover: got ok=%b conf=%h code=%b", frame_ok, conf, err_code);
        end
    endtask

    task automatic test_noise();
        int seen;
        seen = 0;
        tick(1'b1, 8'h00); if (busy !== 1'b0 || frame_err !== 1'b0) seen++;
        tick(1'b1, 8'hFF); if (busy !== 1'b0 || frame_err !== 1'b0) seen++;
        tick(1'b1, 8'h5A); if (busy !== 1'b0 || frame_err !== 1'b0) seen++;
        total++;
        if (seen != 0 || err_cnt !== 8'd2) begin
            bad++; $display("FAIL noise: got %0d reactions cnt=%0d want 0 2", seen, err_cnt);
        end
    endtask

    task automatic test_gap_boundary();
        tick(1'b1, 8'hA5); tick(1'b1, 8'h01);
        for (int i = 1; i < G; i++) tick(1'b0, 8'h00);
        tick(1'b1, 8'h02);
        total++;
        if (frame_err !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL gap_boundary: got err=%b busy=%b want 0 1", frame_err, busy);
        end
        tick(1'b1, 8'h03); tick(1'b1, 8'h04); tick(1'b1, 8'h06); tick(1'b1, 8'h10);
        total++;
        if (frame_ok !== 1'b1 || conf !== 40'h0604030201) begin
            bad++; $display("FAIL gap_boundary_commit: got ok=%b conf=%h want 1 0604030201", frame_ok, conf);
        end
    endtask

    task automatic test_sync_as_payload();
        send7('{8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5});
        total++;
        if (frame_ok !== 1'b1 || conf !== 40'h00000000A5) begin
            bad++; $display("FAIL sync_payload: got ok=%b conf=%h want 1 00000000a5", frame_ok, conf);
        end
    endtask

    task automatic test_back_to_back();
        send7('{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'hF0});
        total++;
        if (frame_ok !== 1'b1 || conf !== 40'h5040302010) begin
            bad++; $display("FAIL b2b_first: got ok=%b conf=%h want 1 5040302010", frame_ok, conf);
        end
        tick(1'b1, SYNC);   // arrives during COMMIT
        total++;
        if (busy !== 1'b1 || frame_ok !== 1'b0) begin
            bad++; $display("FAIL b2b_resync: got busy=%b ok=%b want 1 0", busy, frame_ok);
        end
        for (int i = 0; i < P; i++) tick(1'b1, 8'h01);
        tick(1'b1, 8'h05);
        total++;
        if (frame_ok !== 1'b1 || conf !== 40'h0101010101) begin
            bad++; $display("FAIL b2b_second: got ok=%b conf=%h want 1 0101010101", frame_ok, conf);
        end
    endtask

    task automatic test_reset_midframe();
        int seen;
        seen = 0;
        tick(1'b1, 8'hA5); tick(1'b1, 8'h01);
        async_reset_assert();
        total++;
        if (out_vec() !== '0) begin
            bad++; $display("FAIL midframe_reset: got %h want 0", out_vec());
        end
        reset_release();
        for (int i = 1; i <= P; i++) begin
            tick(1'b1, 8'(i));
            if (busy !== 1'b0 || frame_err !== 1'b0) seen++;
        end
        tick(1'b1, 8'h0F);
        total++;
        if (seen != 0 || frame_ok !== 1'b0 || conf_valid !== 1'b0 || err_cnt !== 8'd0 || conf !== '0) begin
            bad++; $display("FAIL unsynced_ignored: got seen=%0d ok=%b cv=%b cnt=%0d conf=%h",
                            seen, frame_ok, conf_valid, err_cnt, conf);
        end
    endtask

    task automatic test_saturation();
        int wrong;
        wrong = 0;
        async_reset_assert();
        reset_release();
        for (int k = 1; k <= 300; k++) begin
            send7('{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00});
            if (frame_err !== 1'b1 || int'(err_cnt) != ((k < 255) ? k : 255)) begin
                wrong++;
                if (wrong < 4) $display("FAIL sat_frame_%0d: got err=%b cnt=%0d", k, frame_err, err_cnt);
            end
        end
        total++;
        if (wrong != 0 || err_cnt !== 8'd255 || conf_valid !== 1'b0) begin
            bad++; $display("FAIL saturation: got wrong=%0d cnt=%0d cv=%b want 0 255 0", wrong, err_cnt, conf_valid);
        end
    endtask

    task automatic test_random();
        logic       v_q[$];
        logic [7:0] b_q[$];
        logic [7:0] s, b;
        int         gap, errs;
        errs = 0;
        async_reset_assert();
        reset_release();
        for (int seg = 0; seg < 80; seg++) begin
            case ($urandom_range(0, 9))
                0, 1: begin v_q.push_back(1'b1); b_q.push_back(8'($urandom_range(0, 255))); end
                2: for (int i = 0; i < $urandom_range(1, 5); i++) begin v_q.push_back(1'b0); b_q.push_back(8'h00); end
                default: begin
                    v_q.push_back(1'b1); b_q.push_back(SYNC);
                    s = 8'd0;
                    for (int i = 0; i <= P; i++) begin
                        case ($urandom_range(0, 9))
                            0: gap = G - 1;
                            1: gap = G;
                            default: gap = $urandom_range(0, 2);
                        endcase
                        for (int j = 0; j < gap; j++) begin v_q.push_back(1'b0); b_q.push_back(8'h00); end
                        if (i < P) begin
                            b = 8'($urandom_range(0, 255));
                            s = s + b;
                        end else begin
                            b = ($urandom_range(0, 3) == 0) ? (s ^ 8'h3C) : s;
                        end
                        v_q.push_back(1'b1); b_q.push_back(b);
                    end
                end
            endcase
        end
        foreach (v_q[i]) begin
            tick(v_q[i], b_q[i]);
            total++;
            if (out_vec() !== exp_vec() || (frame_ok && frame_err)) begin
                bad++; errs++;
                if (errs < 6) $display("FAIL random_step_%0d: got %h want %h", i, out_vec(), exp_vec());
            end
        end
    endtask

    // Sequence and report
    initial begin
        model_reset();
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_timeout();
        test_noise();
        test_gap_boundary();
        test_sync_as_payload();
        test_back_to_back();
        test_reset_midframe();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: the sequence is bounded, this only guards against a stuck bench.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
